// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: recovers pixel coordinates and colour from hsync/vsync/RGB samples
// and tracks line/frame timing with a SEARCH/CHECK/LOCKED lock state machine.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 1040,
  parameter int H_SYNC      = 120,
  parameter int H_START     = 184,
  parameter int H_ACTIVE    = 800,
  parameter int V_TOTAL     = 666,
  parameter int V_SYNC      = 6,
  parameter int V_START     = 28,
  parameter int V_ACTIVE    = 600,
  parameter int LOCK_FRAMES = 2,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic       line_start,
  output logic       frame_start,
  output logic       locked,
  output logic [7:0] err_count,
  output logic [1:0] fsm_state
);

  // pix_valid is a one-cycle strobe with no ready: the consumer must take pix_x/pix_y/RGB
  // (and line_start/frame_start) in the cycle pix_valid is high; there is no back-pressure.

  typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

  // Horizontal counter is 12 bits so it can reach the 2*H_TOTAL timeout threshold.
  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_TMO   = 12'(2 * H_TOTAL - 1);
  localparam logic [11:0] H_SW    = 12'(H_SYNC);
  localparam logic [11:0] H_BEG   = 12'(H_START);
  localparam logic [11:0] H_END   = 12'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_BEG   = 10'(V_START);
  localparam logic [9:0]  V_END   = 10'(V_START + V_ACTIVE);
  localparam logic [10:0] V_LINES = 11'(V_TOTAL);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  state_t      state, state_n;
  logic [3:0]  good_cnt;
  logic        hs_prev, vs_prev, hs_act, vs_act, h_edge, v_edge;
  logic [11:0] hcnt, hcnt_n, hw, hw_n;
  logic [9:0]  vlin, vlin_n;
  logic [10:0] lcnt, lcnt_n;
  logic        vclr_arm, frame_ok;
  logic        line_bad, frame_bad, bad, frame_good, active_n;

  // Sample decode; a simultaneous hsync+vsync edge closes the line before the frame.
  always_comb begin
    hs_act   = (hsync_in == SYNC_POL);
    vs_act   = (vsync_in == SYNC_POL);
    h_edge   = hs_act && !hs_prev;
    v_edge   = vs_act && !vs_prev;
    hcnt_n   = h_edge ? 12'd0 : ((hcnt == 12'hFFF) ? hcnt : hcnt + 12'd1);
    hw_n     = h_edge ? 12'd1 : ((hs_act && hw != 12'hFFF) ? hw + 12'd1 : hw);
    vlin_n   = vlin;
    if (h_edge) vlin_n = vclr_arm ? 10'd0 : ((vlin == 10'h3FF) ? vlin : vlin + 10'd1);
    lcnt_n   = (h_edge && lcnt != 11'h7FF) ? lcnt + 11'd1 : lcnt;
    line_bad = (h_edge && !(hcnt == H_LAST && hw == H_SW)) || (!h_edge && hcnt == H_TMO);
    frame_bad  = v_edge && !(lcnt_n == V_LINES && frame_ok && !line_bad);
    bad        = pix_en && (line_bad || frame_bad);
    frame_good = pix_en && v_edge && !frame_bad;
    active_n   = (hcnt_n >= H_BEG) && (hcnt_n < H_END) && (vlin_n >= V_BEG) && (vlin_n < V_END);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= SEARCH;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      SEARCH: if (pix_en && v_edge) state_n = CHECK;
      CHECK: begin
        if (bad) state_n = SEARCH;
        else if (frame_good && (good_cnt + 4'd1 >= LOCK_N)) state_n = LOCKED;
      end
      LOCKED: if (bad) state_n = SEARCH;
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    locked    = (state == LOCKED);
    fsm_state = state;
  end

  // Good-frame counter restarts every time the FSM sits in SEARCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt  <= 4'd0;
      err_count <= 8'd0;
    end else begin
      if (state == SEARCH) good_cnt <= 4'd0;
      else if (state == CHECK && frame_good) good_cnt <= good_cnt + 4'd1;
      if (bad && state != SEARCH && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      hcnt        <= 12'd0;
      hw          <= 12'd0;
      vlin        <= 10'd0;
      lcnt        <= 11'd0;
      vclr_arm    <= 1'b0;
      frame_ok    <= 1'b0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_r       <= 4'd0;
      pix_g       <= 4'd0;
      pix_b       <= 4'd0;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hs_prev <= hs_act;
        vs_prev <= vs_act;
        hcnt    <= hcnt_n;
        hw      <= hw_n;
        vlin    <= vlin_n;
        lcnt    <= v_edge ? 11'd0 : lcnt_n;
        if (h_edge) vclr_arm <= 1'b0;
        if (v_edge) vclr_arm <= 1'b1;
        if (v_edge) frame_ok <= 1'b1;
        else if (line_bad) frame_ok <= 1'b0;
        if (active_n) begin
          pix_x       <= 10'(hcnt_n - H_BEG);
          pix_y       <= vlin_n - V_BEG;
          pix_r       <= r_in;
          pix_g       <= g_in;
          pix_b       <= b_in;
          pix_valid   <= locked;
          line_start  <= locked && (hcnt_n == H_BEG);
          frame_start <= locked && (hcnt_n == H_BEG) && (vlin_n == V_BEG);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: shrunken video timing, pixel scoreboard fed by the generator
// and drained by a monitor, plus directed lock/error/reset checks.
module tb_vga_sync_decoder;

  localparam int H_TOTAL = 40, H_SYNC = 4, H_START = 8, H_ACTIVE = 24;
  localparam int V_TOTAL = 20, V_SYNC = 2, V_START = 3, V_ACTIVE = 12;
  localparam int LOCK_FRAMES = 2;
  localparam bit SYNC_POL = 1'b0;
  // vsync falls together with hsync, so active row 0 sits one generator line after V_START.
  localparam int ROW0 = V_START + 1;

  logic       clk = 1'b0;
  logic       rst, pix_en, hsync_in, vsync_in;
  logic [3:0] r_in, g_in, b_in;
  logic       pix_valid, line_start, frame_start, locked;
  logic [9:0] pix_x, pix_y;
  logic [3:0] pix_r, pix_g, pix_b;
  logic [7:0] err_count;
  logic [1:0] fsm_state;

  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  logic [33:0] exp_item;
  int gh = 0, gl = 0, line_len = H_TOTAL;
  bit hs_stuck = 0, exp_lock = 0;
  int n_valid = 0;
  int base, pulses;

  vga_sync_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .LOCK_FRAMES(LOCK_FRAMES), .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .err_count(err_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented pixel must match the oldest expected one.
  always @(negedge clk) begin
    if (pix_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel: unexpected pix_valid at x=%0d y=%0d, none expected", pix_x, pix_y);
      end else begin
        exp_item = exp_q.pop_front();
        check("pixel", {line_start, frame_start, pix_x, pix_y, pix_r, pix_g, pix_b}, exp_item);
      end
    end else if (line_start || frame_start) begin
      checks++;
      errors++;
      $display("FAIL pulse: line_start=%0b frame_start=%0b without pix_valid, expected none",
               line_start, frame_start);
    end
  end

  task automatic drive_sample();
    int x, y;
    logic hs_a, vs_a, act;
    logic [3:0] r, g, b;
    hs_a = (gh < H_SYNC) && !hs_stuck;
    vs_a = (gl < V_SYNC);
    x = gh - H_START;
    y = gl - ROW0;
    act = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
    r = 4'(gh);
    g = 4'(gl);
    b = 4'(gh ^ gl);
    if (x == 0 && y == 0) begin
      r = 4'h5; g = 4'hA; b = 4'h3;
    end
    if (act && exp_lock) exp_q.push_back({(x == 0), (x == 0 && y == 0), 10'(x), 10'(y), r, g, b});
    hsync_in = hs_a ? SYNC_POL : !SYNC_POL;
    vsync_in = vs_a ? SYNC_POL : !SYNC_POL;
    r_in = r;
    g_in = g;
    b_in = b;
    pix_en = 1'b1;
  endtask

  task automatic end_sample();
    pix_en = 1'b0;
    @(posedge clk); #1;
    gh++;
    if (gh >= line_len) begin
      gh = 0;
      line_len = H_TOTAL;
      gl = (gl + 1) % V_TOTAL;
    end
  endtask

  task automatic gen_sample();
    drive_sample();
    @(posedge clk); #1;
    end_sample();
  endtask

  task automatic run_to(input int l, input int h);
    int guard = 0;
    while (!(gl == l && gh == h) && guard < 2 * H_TOTAL * V_TOTAL) begin
      gen_sample();
      guard++;
    end
  endtask

  task automatic relock(input string tag);
    exp_lock = 0;
    run_to(0, 0);
    gen_sample();
    check({tag, "_check_state"}, fsm_state, 2'd1);
    run_to(0, 0);
    gen_sample();
    check({tag, "_not_yet_locked"}, locked, 1'b0);
    run_to(0, 0);
    exp_lock = 1;
    gen_sample();
    check({tag, "_locked"}, locked, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    r_in = 4'd0; g_in = 4'd0; b_in = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", locked, 1'b0);
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_err_count", err_count, 8'd0);
    check("reset_fsm_state", fsm_state, 2'd0);
    check("reset_pix_xy", {pix_x, pix_y}, 20'd0);
    rst = 1'b0;

    // Lock on the third vsync edge, then one full locked frame of pixels.
    relock("startup");
    base = n_valid - 0;
    run_to(0, 0);
    check("pixels_per_frame", n_valid - base, H_ACTIVE * V_ACTIVE);

    // First active pixel: one clock after sampling, with both start pulses.
    run_to(ROW0, H_START);
    drive_sample();
    @(posedge clk); #1;
    check("first_pix_valid", pix_valid, 1'b1);
    check("first_pix_pulses", {line_start, frame_start}, 2'b11);
    check("first_pix_xy", {pix_x, pix_y}, 20'd0);
    check("first_pix_rgb", {pix_r, pix_g, pix_b}, 12'h5A3);
    end_sample();

    // pix_en held low mid-line: outputs hold, no pulses, lock kept.
    run_to(ROW0 + 2, H_START + 5);
    gen_sample();
    pulses = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (pix_valid || line_start || frame_start) pulses++;
    end
    check("hold_no_pulses", pulses, 0);
    check("hold_pix_xy", {pix_x, pix_y}, {10'd5, 10'd2});
    check("hold_pix_r", pix_r, 4'hD);
    check("hold_locked", locked, 1'b1);
    check("hold_err_count", err_count, 8'd0);

    // One line shortened by a sample drops lock at the next hsync edge.
    run_to(0, 0);
    run_to(ROW0 + 3, 0);
    line_len = H_TOTAL - 1;
    run_to(ROW0 + 4, 0);
    exp_lock = 0;
    gen_sample();
    check("short_line_unlocked", locked, 1'b0);
    check("short_line_err_count", err_count, 8'd1);
    relock("after_short");
    check("after_short_err_count", err_count, 8'd1);

    // hsync stuck inactive: timeout when the line counter reaches 2*H_TOTAL.
    run_to(5, 0);
    gen_sample();
    hs_stuck = 1;
    run_to(6, 0);
    exp_lock = 0;
    run_to(7, 0);
    check("timeout_not_yet", locked, 1'b1);
    gen_sample();
    check("timeout_unlocked", locked, 1'b0);
    check("timeout_err_count", err_count, 8'd2);
    run_to(8, 0);
    hs_stuck = 0;
    relock("after_timeout");

    // Reset mid-frame while locked.
    run_to(ROW0 + 1, H_START + 3);
    gen_sample();
    rst = 1'b1;
    exp_lock = 0;
    @(posedge clk); #1;
    check("midrst_outputs", {pix_valid, line_start, frame_start, locked, pix_x, pix_y,
                             pix_r, pix_g, pix_b}, 36'd0);
    check("midrst_err_count", err_count, 8'd0);
    check("midrst_fsm_state", fsm_state, 2'd0);
    rst = 1'b0;
    relock("after_rst");
    run_to(ROW0 + 2, 0);
    check("final_err_count", err_count, 8'd0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
